nibble_serial_accumulator: RTL



---
 rtl/nibble_serial_accumulator_pkg.sv | 26 ++
 rtl/nibble_serial_accumulator_cla_4.sv | 42 ++++
 rtl/nibble_serial_accumulator.sv | 131 +++++++++++++
 3 files changed

// File: rtl/nibble_serial_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// nibble_serial_accumulator_pkg
// Shared definitions for the nibble-serial accumulator and its lookahead slice:
//   - state_t   : controller states (IDLE, ADD, HOLD)
//   - NIB_W     : width of one slice operand (a nibble)
//   - idx_width : width of the nibble index register for a given WIDTH
// -----------------------------------------------------------------------------
package nibble_serial_accumulator_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      HOLD = 2'd2
   } state_t;

   // Bits needed to count WIDTH/NIB_W nibbles; kept at least 1 so a single
   // nibble accumulator still has a legal index register.
   function automatic int idx_width(input int width);
      int n;
      n = width / NIB_W;
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/nibble_serial_accumulator_cla_4.sv
// -----------------------------------------------------------------------------
// nibble_serial_accumulator_cla_4
// The 4-bit carry-lookahead slice (CLA_4). Purely combinational.
// Ports:
//   a, b  in  [3:0]  operand nibbles
//   cin   in  1      carry into bit 0
//   s     out [3:0]  sum nibble
//   pg    out 1      group propagate (AND of all bit propagates)
//   gg    out 1      group generate
// -----------------------------------------------------------------------------
module nibble_serial_accumulator_cla_4
   import nibble_serial_accumulator_pkg::*;
(
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic             cin,
   output logic [NIB_W-1:0] s,
   output logic             pg,
   output logic             gg
);

   logic [NIB_W-1:0] p;
   logic [NIB_W-1:0] g;
   logic [NIB_W-1:0] c;

   assign p = a ^ b;
   assign g = a & b;

   // Every internal carry is expanded directly from cin so no carry ripples
   // through the slice.
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);

   assign s  = p ^ c;
   assign pg = &p;
   assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/nibble_serial_accumulator.sv
// -----------------------------------------------------------------------------
// nibble_serial_accumulator
// Adds register B into accumulator A once per Run press, one nibble per clock,
// through a single shared 4-bit lookahead slice.
// Parameters:
//   WIDTH  accumulator/operand width; multiple of 4, at least 4
// Ports:
//   Clk    in   1      system clock, rising edge
//   Reset  in   1      synchronous, active-high; clears all state
//   Run    in   1      level; requests one accumulation per press
//   LoadB  in   1      level; loads B from SW while idle (wins over Run)
//   SW     in   WIDTH  switch operand
//   Sum    out  WIDTH  accumulator A (partially updated while Busy)
//   Cout   out  1      carry-out of the last completed addition
//   Busy   out  1      nibble additions in progress
//   Done   out  1      one-cycle pulse when an addition completes
// -----------------------------------------------------------------------------
module nibble_serial_accumulator
   import nibble_serial_accumulator_pkg::*;
#(
   parameter int WIDTH = 16
)
(
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Run,
   input  logic             LoadB,
   input  logic [WIDTH-1:0] SW,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Busy,
   output logic             Done
);

   localparam int N     = WIDTH / NIB_W;
   localparam int IDX_W = idx_width(WIDTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [IDX_W-1:0] idx_q;
   logic             carry_q;
   logic             cout_q;
   logic             done_q;

   logic [NIB_W-1:0] nib_s;
   logic             nib_pg;
   logic             nib_gg;
   logic             carry_next;
   logic             last_nib;

   // Operand nibbles are picked by the index register; {idx_q, 2'b00} is the
   // bit offset of nibble idx_q.
   nibble_serial_accumulator_cla_4 u_cla (
      .a   (a_q[{idx_q, 2'b00} +: NIB_W]),
      .b   (b_q[{idx_q, 2'b00} +: NIB_W]),
      .cin (carry_q),
      .s   (nib_s),
      .pg  (nib_pg),
      .gg  (nib_gg)
   );

   assign carry_next = nib_gg | (nib_pg & carry_q);
   assign last_nib   = (idx_q == LAST_IDX);

   // State register and datapath registers.
   always_ff @(posedge Clk) begin
      // NOTE: state uses non-blocking assignments so every register samples
      // the pre-edge values; blocking here would create order-dependent races.
      if (Reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (LoadB) begin
                  b_q <= SW;
               end else if (Run) begin
                  idx_q   <= '0;
                  carry_q <= 1'b0;
               end
            end
            ADD: begin
               a_q[{idx_q, 2'b00} +: NIB_W] <= nib_s;
               carry_q                      <= carry_next;
               if (last_nib) begin
                  cout_q <= carry_next;
                  done_q <= 1'b1;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            HOLD: begin
               // LoadB is ignored; waits for Run release in next-state logic.
            end
            default: begin
            end
         endcase
      end
   end

   // Next-state logic.
   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch forms.
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (!LoadB && Run) state_d = ADD;
         ADD:     if (last_nib)      state_d = HOLD;
         HOLD:    if (!Run)          state_d = IDLE;
         default:                    state_d = IDLE;
      endcase
   end

   // Outputs: all driven from flops, Busy is a decode of the state register.
   always_comb begin
      Sum  = a_q;
      Cout = cout_q;
      Busy = (state_q == ADD);
      Done = done_q;
   end

endmodule
